game_flow_ctrl: RTL and testbench

//  Top-level sequencer for the puzzle-game datapath (play). Owns the game state
//  (CHOSE_BOARD/GAME_INITIAL/GAMING/WINNED) and drives play's game_status, act
//  and origin_bd from raw, debounced button levels. Handles board selection from
//  a 4-entry table, gates moves to GAMING only, and keeps move count and

---
 rtl/game_flow_ctrl.sv | 172 +++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - puzzle game sequencer: board select, move gating, move/second statistics
module game_flow_ctrl #(
   parameter logic [11:0] BOARD0        = 12'b001_011_000_010,
   parameter logic [11:0] BOARD1        = 12'b011_001_010_000,
   parameter logic [11:0] BOARD2        = 12'b000_010_011_001,
   parameter logic [11:0] BOARD3        = 12'b010_000_001_011,
   parameter int unsigned INIT_CYCLES   = 4,
   parameter int unsigned TICKS_PER_SEC = 100_000_000,
   parameter int unsigned MOVE_W        = 10,
   parameter int unsigned SEC_W         = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        btn_act,
   input  logic              btn_ok,
   input  logic              win_flag,
   output logic [1:0]        game_status,
   output logic [3:0]        act_out,
   output logic [11:0]       origin_bd,
   output logic [1:0]        board_sel,
   output logic [MOVE_W-1:0] move_cnt,
   output logic [SEC_W-1:0]  sec_cnt
);

   localparam logic [1:0] ST_CHOSE  = 2'b00;
   localparam logic [1:0] ST_GAMING = 2'b01;
   localparam logic [1:0] ST_INIT   = 2'b10;
   localparam logic [1:0] ST_WIN    = 2'b11;

   localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic [3:0]        act_cur_q, act_cur_d, act_prev_q, act_prev_d;
   logic              ok_cur_q, ok_cur_d, ok_prev_q, ok_prev_d;
   logic [1:0]        arm_q, arm_d;
   logic [1:0]        board_sel_q, board_sel_d;
   logic [11:0]       origin_q, origin_d;
   logic [3:0]        act_out_q, act_out_d;
   logic [MOVE_W-1:0] move_q, move_d;
   logic [SEC_W-1:0]  sec_q, sec_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [INIT_W-1:0] init_q, init_d;

   logic       armed;
   logic [3:0] act_rise;
   logic       ok_rise;
   logic       act_valid;
   logic       init_done;

   // Rises are honoured only once both edge registers hold post-reset samples,
   // so a button held through reset release never looks like a fresh press.
   assign armed     = arm_q[1];
   assign act_rise  = act_cur_q & ~act_prev_q & {4{armed}};
   assign ok_rise   = ok_cur_q & ~ok_prev_q & armed;
   assign act_valid = (act_rise != 4'b0) && ((act_rise & (act_rise - 4'd1)) == 4'b0);
   assign init_done = (init_q == INIT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_CHOSE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CHOSE:  if (ok_rise)   state_d = ST_INIT;
         ST_INIT:   if (init_done) state_d = ST_GAMING;
         ST_GAMING: begin
            if (win_flag)     state_d = ST_WIN;
            else if (ok_rise) state_d = ST_CHOSE;
         end
         ST_WIN:    if (ok_rise)   state_d = ST_CHOSE;
         default:   state_d = ST_CHOSE;
      endcase
   end

   always_comb begin
      act_cur_d   = btn_act;
      act_prev_d  = act_cur_q;
      ok_cur_d    = btn_ok;
      ok_prev_d   = ok_cur_q;
      arm_d       = {arm_q[0], 1'b1};
      board_sel_d = board_sel_q;
      act_out_d   = 4'b0;
      move_d      = move_q;
      sec_d       = sec_q;
      tick_d      = tick_q;
      init_d      = init_q;

      case (state_q)
         ST_CHOSE: begin
            if (ok_rise) begin
               move_d = '0;
               sec_d  = '0;
               tick_d = '0;
               init_d = '0;
            end else if (act_valid) begin
               if (act_rise[0])      board_sel_d = board_sel_q + 2'd1;
               else if (act_rise[1]) board_sel_d = board_sel_q - 2'd1;
            end
         end
         ST_INIT: begin
            init_d = init_done ? '0 : init_q + 1'b1;
         end
         ST_GAMING: begin
            if (tick_q == TICK_LAST) begin
               tick_d = '0;
               if (sec_q != '1) sec_d = sec_q + 1'b1;
            end else begin
               tick_d = tick_q + 1'b1;
            end
            // win_flag and give-up both swallow a move arriving in the same cycle
            if (!win_flag && !ok_rise && act_valid) begin
               act_out_d = act_rise;
               if (move_q != '1) move_d = move_q + 1'b1;
            end
         end
         default: ;
      endcase

      case (board_sel_d)
         2'd0:    origin_d = BOARD0;
         2'd1:    origin_d = BOARD1;
         2'd2:    origin_d = BOARD2;
         default: origin_d = BOARD3;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         act_cur_q   <= 4'b0;
         act_prev_q  <= 4'b0;
         ok_cur_q    <= 1'b0;
         ok_prev_q   <= 1'b0;
         arm_q       <= 2'b0;
         board_sel_q <= 2'd0;
         origin_q    <= BOARD0;
         act_out_q   <= 4'b0;
         move_q      <= '0;
         sec_q       <= '0;
         tick_q      <= '0;
         init_q      <= '0;
      end else begin
         act_cur_q   <= act_cur_d;
         act_prev_q  <= act_prev_d;
         ok_cur_q    <= ok_cur_d;
         ok_prev_q   <= ok_prev_d;
         arm_q       <= arm_d;
         board_sel_q <= board_sel_d;
         origin_q    <= origin_d;
         act_out_q   <= act_out_d;
         move_q      <= move_d;
         sec_q       <= sec_d;
         tick_q      <= tick_d;
         init_q      <= init_d;
      end
   end

   assign game_status = state_q;
   assign act_out     = act_out_q;
   assign origin_bd   = origin_q;
   assign board_sel   = board_sel_q;
   assign move_cnt    = move_q;
   assign sec_cnt     = sec_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - self-checking bench for game_flow_ctrl
module tb_game_flow_ctrl;

   localparam int TPS  = 10;
   localparam int INIT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  btn_act = 4'b0;
   logic        btn_ok = 1'b0;
   logic        win_flag = 1'b0;
   logic [1:0]  game_status;
   logic [3:0]  act_out;
   logic [11:0] origin_bd;
   logic [1:0]  board_sel;
   logic [9:0]  move_cnt;
   logic [9:0]  sec_cnt;

   game_flow_ctrl #(
      .INIT_CYCLES   (INIT),
      .TICKS_PER_SEC (TPS),
      .MOVE_W        (10),
      .SEC_W         (10)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_act     (btn_act),
      .btn_ok      (btn_ok),
      .win_flag    (win_flag),
      .game_status (game_status),
      .act_out     (act_out),
      .origin_bd   (origin_bd),
      .board_sel   (board_sel),
      .move_cnt    (move_cnt),
      .sec_cnt     (sec_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int g0 = 0;
   logic [3:0] exp_q[$];

   typedef struct {
      logic [3:0] act;
      logic       win;
      logic [1:0] sel;
   } vec_t;
   vec_t vt[11];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic [11:0] board_of(input logic [1:0] s);
      case (s)
         2'd0:    return 12'b001_011_000_010;
         2'd1:    return 12'b011_001_010_000;
         2'd2:    return 12'b000_010_011_001;
         default: return 12'b010_000_001_011;
      endcase
   endfunction

   task automatic wait_status(input logic [1:0] s, input int max, input string name);
      int n = 0;
      while (game_status !== s && n < max) begin
         tick();
         n++;
      end
      chk(name, game_status, s);
   endtask

   task automatic press_act(input logic [3:0] a, input bit push);
      btn_act = a;
      if (push) exp_q.push_back(a);
      repeat (3) tick();
      btn_act = 4'b0;
      repeat (2) tick();
   endtask

   // Enters a game from CHOSE_BOARD, pokes a direction during GAME_INITIAL and
   // measures how many cycles game_status reads 10.
   task automatic enter_game(input string tag);
      int n10 = 0;
      btn_ok = 1'b1;
      wait_status(2'b10, 6, {tag, "_to_init"});
      while (game_status === 2'b10 && n10 < 20) begin
         if (n10 == 0) btn_act = 4'b0001;
         if (n10 == 1) btn_act = 4'b0000;
         if (n10 == 2) btn_ok = 1'b0;
         tick();
         n10++;
      end
      btn_ok = 1'b0;
      btn_act = 4'b0;
      g0 = cyc;
      chk({tag, "_init_len"}, n10, INIT);
      chk({tag, "_gaming"}, game_status, 2'b01);
      chk({tag, "_move0"}, move_cnt, 0);
      chk({tag, "_sec0"}, sec_cnt, 0);
   endtask

   // act_out scoreboard: every nonzero pulse must match the next queued press
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (act_out !== 4'b0) begin
            if (exp_q.size() == 0) chk("act_unexpected", act_out, 4'b0);
            else chk("act_out", act_out, exp_q.pop_front());
         end
      end
   end

   initial begin
      vt[0]  = '{4'b0010, 1'b0, 2'd3};
      vt[1]  = '{4'b0001, 1'b0, 2'd0};
      vt[2]  = '{4'b0001, 1'b0, 2'd1};
      vt[3]  = '{4'b0101, 1'b0, 2'd1};
      vt[4]  = '{4'b0100, 1'b0, 2'd1};
      vt[5]  = '{4'b1000, 1'b1, 2'd1};
      vt[6]  = '{4'b0010, 1'b0, 2'd0};
      vt[7]  = '{4'b0011, 1'b0, 2'd0};
      vt[8]  = '{4'b0010, 1'b0, 2'd3};
      vt[9]  = '{4'b0001, 1'b0, 2'd0};
      vt[10] = '{4'b0001, 1'b0, 2'd1};

      repeat (3) tick();
      #2 reset = 1'b1;

      for (int i = 0; i < 20; i++) begin
         tick();
         chk("rst_status", game_status, 2'b00);
         chk("rst_origin", origin_bd, 12'b001_011_000_010);
         chk("rst_sel", board_sel, 2'd0);
         chk("rst_act", act_out, 4'b0);
      end
      chk("rst_move", move_cnt, 0);
      chk("rst_sec", sec_cnt, 0);

      for (int i = 0; i < 11; i++) begin
         btn_act = vt[i].act;
         win_flag = vt[i].win;
         repeat (2) tick();
         btn_act = 4'b0;
         win_flag = 1'b0;
         repeat (2) tick();
         chk($sformatf("vec%0d_status", i), game_status, 2'b00);
         chk($sformatf("vec%0d_sel", i), board_sel, vt[i].sel);
         chk($sformatf("vec%0d_origin", i), origin_bd, board_of(vt[i].sel));
      end

      enter_game("g1");
      press_act(4'b0001, 1'b1);
      press_act(4'b0010, 1'b1);
      press_act(4'b0100, 1'b1);
      press_act(4'b1000, 1'b1);
      press_act(4'b0100, 1'b1);
      chk("g1_move5", move_cnt, 5);
      chk("g1_sb_drain", exp_q.size(), 0);
      while (cyc - g0 < 35) tick();
      chk("g1_sec35", sec_cnt, 3);

      btn_act = 4'b0010;
      tick();
      win_flag = 1'b1;
      tick();
      win_flag = 1'b0;
      btn_act = 4'b0;
      chk("win_status", game_status, 2'b11);
      press_act(4'b0001, 1'b0);
      repeat (10) tick();
      chk("win_hold", game_status, 2'b11);
      chk("win_move", move_cnt, 5);
      chk("win_sec_frozen", sec_cnt, 3);
      btn_ok = 1'b1;
      repeat (3) tick();
      btn_ok = 1'b0;
      tick();
      chk("win_exit", game_status, 2'b00);
      chk("win_exit_move", move_cnt, 5);
      chk("win_exit_sec", sec_cnt, 3);
      chk("win_exit_sel", board_sel, 2'd1);

      enter_game("g2");
      press_act(4'b1000, 1'b1);
      press_act(4'b0001, 1'b1);
      btn_act = 4'b0100;
      btn_ok = 1'b1;
      repeat (3) tick();
      btn_act = 4'b0;
      btn_ok = 1'b0;
      tick();
      chk("giveup_status", game_status, 2'b00);
      chk("giveup_move", move_cnt, 2);
      chk("giveup_sel", board_sel, 2'd1);

      enter_game("g3");
      for (int i = 0; i < 5; i++) press_act(4'b0001 << (i % 4), 1'b1);
      chk("g3_move5", move_cnt, 5);
      @(posedge clk);
      #3 reset = 1'b0;
      btn_act = 4'b0001;
      #1;
      chk("arst_status", game_status, 2'b00);
      chk("arst_sel", board_sel, 2'd0);
      chk("arst_origin", origin_bd, 12'b001_011_000_010);
      chk("arst_act", act_out, 4'b0);
      chk("arst_move", move_cnt, 0);
      chk("arst_sec", sec_cnt, 0);
      repeat (3) tick();
      #2 reset = 1'b1;
      repeat (5) tick();
      btn_act = 4'b0;
      repeat (3) tick();
      chk("held_thru_rst_sel", board_sel, 2'd0);
      chk("held_thru_rst_status", game_status, 2'b00);
      press_act(4'b0001, 1'b0);
      chk("post_rst_press", board_sel, 2'd1);
      chk("final_sb_drain", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
